// File: rtl/serial_add_pkg.sv
// Shared types and widths for the serial 2x4b adder feeder.
// Defining SERIAL_ADD_FEEDER_FLUSH_EN adds a carry-flush beat after every high nibble.
package serial_add_pkg;

  localparam int OP_W  = 8;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

`ifdef SERIAL_ADD_FEEDER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  // The final beat of an operation is where the next pair may be taken.
  function automatic logic last_beat(state_e s);
    return (s == ST_FLUSH) || ((s == ST_HI) && !FLUSH_EN);
  endfunction

endpackage

// File: rtl/serial_add_feeder_opreg.sv
// Operand holding register: {A, B} loaded on accept, cleared by async active-low reset.
module serial_add_feeder_opreg
  import serial_add_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [2*OP_W-1:0]   d,
  output logic [2*OP_W-1:0]   q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_add_feeder.sv
// Splits each accepted 8b operand pair into low/high nibble beats for a serial 2x4b adder.
// Build option SERIAL_ADD_FEEDER_FLUSH_EN appends a zero carry-flush beat to each operation.
module serial_add_feeder
  import serial_add_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [OP_W-1:0]  in0,
  input  logic [OP_W-1:0]  in1,
  output logic [NIB_W-1:0] out0,
  output logic [NIB_W-1:0] out1,
  output logic             out_val,
  output logic             out_hi,
  output logic             out_flush,
  output logic [1:0]       dbg_state
);

  // Handshake: a pair transfers on a rising edge with in_val=1 and in_rdy=1.
  // in_rdy depends on state only, so upstream may raise in_val at any time.

  state_e            state_q;
  state_e            state_d;
  logic              accept;
  logic              flush_beat;
  logic [2*OP_W-1:0] hold_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;

  // Gating with reset keeps in_rdy low while reset is asserted even though state is IDLE.
  assign in_rdy    = reset & ((state_q == ST_IDLE) | last_beat(state_q));
  assign accept    = in_val & in_rdy;
  assign a_q       = hold_q[2*OP_W-1:OP_W];
  assign b_q       = hold_q[OP_W-1:0];
  assign dbg_state = state_q;

  serial_add_feeder_opreg u_opreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .d     ({in0, in1}),
    .q     (hold_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = accept ? ST_LO : ST_IDLE;
      ST_LO:    state_d = ST_HI;
`ifdef SERIAL_ADD_FEEDER_FLUSH_EN
      ST_HI:    state_d = ST_FLUSH;
      ST_FLUSH: state_d = accept ? ST_LO : ST_IDLE;
`else
      ST_HI:    state_d = accept ? ST_LO : ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out0       = '0;
    out1       = '0;
    out_val    = 1'b0;
    out_hi     = 1'b0;
    flush_beat = 1'b0;
    case (state_q)
      ST_LO: begin
        out0    = a_q[NIB_W-1:0];
        out1    = b_q[NIB_W-1:0];
        out_val = 1'b1;
      end
      ST_HI: begin
        out0    = a_q[OP_W-1:NIB_W];
        out1    = b_q[OP_W-1:NIB_W];
        out_val = 1'b1;
        out_hi  = 1'b1;
      end
      ST_FLUSH: begin
        out_val    = 1'b1;
        flush_beat = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SERIAL_ADD_FEEDER_FLUSH_EN
  assign out_flush = flush_beat;
`else
  assign out_flush = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_feeder.sv
// Scoreboard bench for serial_add_feeder, with a behavioural serial 2x4b adder downstream.
module tb_serial_add_feeder;

  localparam int W = 15; // {rdy, hi, flush, out0, out1, adder_sum}

`ifdef SERIAL_ADD_FEEDER_FLUSH_EN
  localparam bit TB_FLUSH = 1'b1;
`else
  localparam bit TB_FLUSH = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [3:0] out0;
  logic [3:0] out1;
  logic       out_val;
  logic       out_hi;
  logic       out_flush;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;
  logic         carry;

  serial_add_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in0       (in0),
    .in1       (in1),
    .out0      (out0),
    .out1      (out1),
    .out_val   (out_val),
    .out_hi    (out_hi),
    .out_flush (out_flush),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Beats for one pair, with the sum a carry-propagating 4b serial adder should produce.
  task automatic push_op(input logic [7:0] a, input logic [7:0] b);
    int lo;
    int hi;
    lo = (a % 16) + (b % 16);
    hi = (a / 16) + (b / 16) + (lo / 16);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'(a % 16), 4'(b % 16), 4'(lo % 16)});
    exp_q.push_back({!TB_FLUSH, 1'b1, 1'b0, 4'(a / 16), 4'(b / 16), 4'(hi % 16)});
    if (TB_FLUSH)
      exp_q.push_back({1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'(hi / 16)});
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor + accept tracker ----------------
  always @(negedge clk) begin
    logic [4:0]   s5;
    logic [W-1:0] act;
    logic [W-1:0] exp;
    logic [W-1:0] mask;
    if (reset && out_val) begin
      s5    = {1'b0, out0} + {1'b0, out1} + {4'b0, carry};
      carry = s5[4];
      act   = {in_rdy, out_hi, out_flush, out0, out1, s5[3:0]};
      // Without flush beats the adder carry leaks into the next op, so sums are not meaningful.
      mask  = TB_FLUSH ? {W{1'b1}} : {{(W-4){1'b1}}, 4'h0};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got %h expected none at %0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        if ((act & mask) !== (exp & mask)) begin
          n_err++;
          $display("FAIL beat: got %h expected %h at %0t", act & mask, exp & mask, $time);
        end
      end
    end
    if (reset && in_val && in_rdy)
      push_op(in0, in1);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit done;
    done   = 1'b0;
    in_val = 1'b1;
    in0    = a;
    in1    = b;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_rdy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 16'd0, 16'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_val) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    carry  = 1'b0;
    reset  = 1'b0;
    in_val = 1'b0;
    in0    = '0;
    in1    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_rdy", 16'(in_rdy), 16'd0);
    check("reset_outputs", {10'd0, out_val, out_hi, out_flush, 3'd0}, 16'd0);
    check("reset_nibbles", {8'd0, out0, out1}, 16'd0);
    in_val = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_val = 1'b0;
    #1;
    check("rdy_after_release", 16'(in_rdy), 16'd1);

    // single op: (C,5) then (3,1)
    send(8'h3C, 8'h15);
    in_val = 1'b0;
    check("latency_lo_beat", {out_val, out_hi, 6'd0, out0, out1}, {1'b1, 1'b0, 6'd0, 4'hC, 4'h5});
    drain();
    check("idle_after_op", {in_rdy, out_val}, 16'b10);

    // back-to-back with in_val held
    send(8'hFF, 8'h01);
    send(8'h12, 8'h34);
    in_val = 1'b0;
    drain();

    // backpressure: a pair offered during LO must be ignored
    send(8'h12, 8'h34);
    in0    = 8'h77;
    in1    = 8'hAA;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check("bp_hold_b", {out_hi, 7'd0, out0, out1}, {1'b1, 7'd0, 4'h1, 4'h3});
    drain();

    // reset during HI
    send(8'hA5, 8'h5A);
    in_val = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_hi", 16'(out_hi), 16'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {11'd0, in_rdy, out_val, out_hi, out_flush, 1'b0}, 16'd0);
    check("mid_reset_nibbles", {8'd0, out0, out1}, 16'd0);
    exp_q.delete();
    carry = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rdy_after_mid_reset", {in_rdy, out_val}, 16'b10);
    repeat (3) @(posedge clk);
    #1;
    check("no_residual_beat", 16'(out_val), 16'd0);

    // chained adder run: sums 0,0,[1],2,0
    send(8'hF0, 8'h10);
    send(8'h01, 8'h01);
    in_val = 1'b0;
    drain();

    // random in_val over 50 cycles
    for (int i = 0; i < 50; i++) begin
      in_val = 1'($urandom_range(0, 1));
      in0    = 8'($urandom);
      in1    = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_feeder.md
SERIAL_ADD_FEEDER -- requirements
Module: serial_add_feeder

Interface
REQ-001 SHALL have no parameters; all widths are fixed (operand 8b, nibble 4b).
REQ-002 SHALL have port clk, input, 1b: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1b: asynchronous, active-low reset.
REQ-004 SHALL have port in_val, input, 1b: an upstream operand pair is valid.
REQ-005 SHALL have port in_rdy, output, 1b: the block accepts a pair this cycle.
REQ-006 SHALL have port in0, input, 8b: operand A.
REQ-007 SHALL have port in1, input, 8b: operand B.
REQ-008 SHALL have port out0, output, 4b: operand A nibble to the serial 2x4b adder.
REQ-009 SHALL have port out1, output, 4b: operand B nibble to the serial 2x4b adder.
REQ-010 SHALL have port out_val, output, 1b: out0/out1 carry a live nibble or flush beat.
REQ-011 SHALL have port out_hi, output, 1b: current beat is the high nibble.
REQ-012 SHALL have port out_flush, output, 1b: current beat is a carry-flush beat.

Function
REQ-013 SHALL implement an FSM with states IDLE, LO, HI and FLUSH.
REQ-014 SHALL accept a pair on a rising edge where in_val=1 and in_rdy=1, capturing in0/in1 into a 16b holding register.
REQ-015 SHALL drive in_rdy from state only, never from in_val: 1 in IDLE, 1 in the last beat of an operation (HI without flush, FLUSH with flush), else 0.
REQ-016 SHALL transition on accept to LO; LO->HI unconditionally; HI->FLUSH (flush enabled) or HI->LO/IDLE per accept; FLUSH->LO/IDLE per accept.
REQ-017 SHALL in LO drive out0=A[3:0], out1=B[3:0], out_val=1, out_hi=0, out_flush=0.
REQ-018 SHALL in HI drive out0=A[7:4], out1=B[7:4], out_val=1, out_hi=1, out_flush=0.
REQ-019 SHALL in FLUSH drive out0=0, out1=0, out_val=1, out_hi=0, out_flush=1.
REQ-020 SHALL in IDLE drive out0=0, out1=0 and out_val=out_hi=out_flush=0.
REQ-021 SHALL produce the first LO beat exactly one cycle after the accept edge, i.e. a latency of 1.
REQ-022 SHALL sustain back-to-back throughput of one pair per 2 cycles (3 with flush), with no idle gap between operations.
REQ-023 SHALL ignore in0/in1/in_val whenever in_rdy=0; the holding register is unchanged.

Reset
REQ-024 SHALL on reset=0 immediately enter IDLE, clear the holding register and force all outputs, including in_rdy, to 0.
REQ-025 SHALL abort any in-flight operation on a mid-operation reset; the operation is lost and not resumed.
REQ-026 SHALL assert in_rdy=1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, with SERIAL_ADD_FEEDER_FLUSH_EN defined, insert one FLUSH beat after every HI beat so the downstream carry-out drains before the next LO nibble.
REQ-028 SHALL, without SERIAL_ADD_FEEDER_FLUSH_EN, never enter FLUSH; out_flush is tied to 0 and HI is the last beat.

Structure
REQ-029 SHALL take the state enum, OP_W=8 and NIB_W=4 from the shared package serial_add_pkg.
REQ-030 SHALL place the 16b enable-loaded holding register with async active-low clear in the sub-module serial_add_feeder_opreg.

Verification
REQ-031 SHALL cover single op A=0x3C, B=0x15: out0/out1 beats are (C,5) with out_hi=0, then (3,1) with out_hi=1, then IDLE (plus a flush beat (0,0) with out_flush=1 when FLUSH_EN).
REQ-032 SHALL cover back-to-back ops 0xFF+0x01 then 0x12+0x34 with in_val held: beats (F,1),(F,0),[(0,0)],(2,4),(1,3), with in_rdy high only on the last beat of each op.
REQ-033 SHALL cover backpressure: in_val=1 in LO with in1=0xAA is ignored and the holding register keeps the prior B.
REQ-034 SHALL cover reset asserted during HI: outputs are 0 immediately and in_rdy=1 one cycle after release, with no residual HI beat.
REQ-035 SHALL cover a chained end-to-end run with the 2x4b adder downstream and FLUSH_EN: 0xF0+0x10 then 0x01+0x01 yields nibble sums 0,0,[1 flush],2,0, the flush beat absorbing the carry.
REQ-036 SHALL cover in_val toggling randomly over 50 cycles: every accepted pair is emitted exactly once and in order (scoreboard).
